// File: rtl/seq_mult.sv
// seq_mult: iterative shift-add multiplier, one multiplier bit per clock.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   operands and mode presented
//   o_in_ready   block can accept an operation (state IDLE)
//   i_a, i_b     multiplicand, multiplier (WIDTH bits)
//   i_is_signed  1: operands/product are two's complement, 0: unsigned
//   o_out_valid  o_p holds a completed product (state DONE)
//   i_out_ready  consumer takes o_p
//   o_p          product (2*WIDTH bits), held until the next result load
//   o_busy       operation in flight (RUN or DONE)
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for an operation, o_in_ready high
//   S_RUN  | retiring one multiplier bit per edge, WIDTH edges total
//   S_DONE | result presented, waiting for i_out_ready
`timescale 1ns/1ps

module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_is_signed,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [2*WIDTH-1:0] o_p,
  output logic               o_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_load_p;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg;
  logic [2*WIDTH-1:0] r_p;

  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_p_nxt;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_busy      = 1'b0;
    o_out_valid = 1'b0;
    w_accept    = 1'b0;
    w_load_p    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        // Down-counter reaching zero marks the WIDTH-th RUN edge.
        if (r_cnt == '0) begin
          w_load_p    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  // Signed operands are reduced to magnitudes; the most negative value
  // maps to 2^(WIDTH-1), which is representable as WIDTH-bit unsigned.
  assign w_a_neg = i_is_signed & i_a[WIDTH-1];
  assign w_b_neg = i_is_signed & i_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_a + ONE_W) : i_a;
  assign w_b_mag = w_b_neg ? (~i_b + ONE_W) : i_b;

  // r_mcand is kept pre-shifted, so it always equals |a| << bit_index.
  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = r_acc + w_addend;
  assign w_p_nxt   = r_neg ? (~w_acc_nxt + ONE_2W) : w_acc_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
    end else begin
      if (w_accept) begin
        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_cnt    <= CNT_LAST;
        r_acc    <= '0;
        r_neg    <= w_a_neg ^ w_b_neg;
      end else if (r_state == S_RUN) begin
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - 1'b1;
        r_acc    <= w_acc_nxt;
      end
      if (w_load_p) begin
        r_p <= w_p_nxt;
      end
    end
  end

  assign o_p = r_p;

endmodule

// File: doc/seq_mult.md
# seq_mult

Iterative shift-add multiplier, parametrised in operand width, with an unsigned/signed (two's complement) mode select and valid/ready handshakes on input and output. It retires one multiplier bit per clock and accepts one operation at a time. It is the area-lean, width-scalable successor to the fixed 4-bit parallel array multiplier. It sits between an operand producer and a result consumer that may apply backpressure.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept an operation; high exactly when the FSM is in IDLE.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 means a, b and p are two's complement; 0 means unsigned; sampled with the operands.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer takes p.
- p  out  2*WIDTH  product.
- busy  out  1  high in RUN or DONE.

## Operation
- Reset (rst_n low) asynchronously forces the following, with no partial state retained:
  - state = IDLE, out_valid = 0, p = 0, busy = 0;
  - the internal accumulator, operand registers and bit counter are cleared;
  - in_ready = 1 once in IDLE.
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - Accept happens on a clock edge with in_valid && in_ready.
  - On accept, register a, b and is_signed. The later values of these inputs are ignored until the next accept.
  - In signed mode, register the magnitudes |a| and |b| as WIDTH-bit unsigned values, plus the result sign neg = a[MSB] ^ b[MSB]. The most negative value has magnitude 2^(WIDTH-1), which fits unsigned.
  - In unsigned mode, neg = 0.
  - Clear the accumulator and bit counter, then go to RUN.
- **RUN:**
  - On each edge: if the current multiplier LSB is 1, add the multiplicand, shifted by the counter, into the 2*WIDTH-bit accumulator. Then shift the multiplier right and increment the counter.
  - After exactly WIDTH RUN edges, go to DONE and load p with the result:
    - p = accumulator, or p = the two's complement negation of the accumulator when neg = 1;
    - the result is taken modulo 2^(2*WIDTH).
  - The product always fits, so there is no overflow flag.
- **DONE:**
  - out_valid = 1.
  - On an edge with out_ready = 1, go to IDLE with out_valid = 0.
  - p holds its value after the handshake until the next DONE load.
- in_valid while not in IDLE is ignored. No queuing; the producer must hold in_valid.
- A zero operand does not short-circuit; latency is fixed regardless of data.

## Timing
- Call the accept edge E0.
- RUN occupies edges E1..EWIDTH. The edge EWIDTH enters DONE and loads p.
- out_valid is high from just after EWIDTH, so latency from accept to out_valid is WIDTH cycles.
- With out_ready held high, the output handshake is at EWIDTH+1 and in_ready is high again after it. The next accept can be at EWIDTH+2.
- Minimum initiation interval is WIDTH+2 cycles.
- in_ready and busy are decoded from state and are mutually exclusive.
- out_valid and p are registered.
- While out_valid = 1 and out_ready = 0, p, out_valid and busy are stable and in_ready = 0, indefinitely.
- Reset asserted mid-RUN or mid-DONE aborts the operation. out_valid falls immediately (asynchronously), and no result is delivered for the aborted operands.
- After rst_n deasserts, the first edge may accept.

## Test plan
- **Unsigned, WIDTH=4.** Stimulus: a = 15, b = 15, is_signed = 0, accept at E0, out_ready = 1.
  - Required: p = 0xE1 (225).
  - out_valid rises after E4 and drops after E5; in_ready is high again from E5.
- **Signed, WIDTH=4.** Stimulus: (a = -8, b = -8), then (a = -8, b = 7), then (a = 0, b = -3), all with is_signed = 1.
  - Required: p = 0x40, then 0xC8, then 0x00, each with latency 4.
  - Repeat the first case with is_signed = 0: p = 0x40 (8*8).
- **Backpressure.** Hold out_ready = 0 for 6 cycles after out_valid rises, with in_valid held high carrying new operands.
  - Required: p stable, in_ready = 0, the new operands not accepted.
  - Raise out_ready: handshake on that edge, then the new operands are accepted on the next edge.
- **Back-to-back.** Keep in_valid = 1 and out_ready = 1 continuously for 3 operations: 3*5, 6*7, 9*2 (unsigned).
  - Required: p = 15, 42, 18 in order, with accept edges exactly 6 cycles apart.
- **Reset mid-run.** Assert rst_n low at E2 of an operation, hold it for 1 cycle, then release.
  - Required: out_valid = 0, p = 0, busy = 0 and in_ready = 1 immediately, and no stale result appears.
  - A subsequent 2*3 gives p = 6.
- **WIDTH=8 instance.** Stimulus: 255*255 unsigned, then -128*-128 signed.
  - Required: p = 0xFE01 and then 0x4000, each with out_valid 8 cycles after accept.
